// File: rtl/regfile_access_arbiter_if.sv
// Requester-side bundle of the register-file arbiter: APB slave bus
// plus the core register-access port.
//
// Signals:
//   paddr/pwrite/psel/penable/pwdata  APB request from the host
//   prdata/pready/pslverr             APB completion back to the host
//   core_req/core_we/core_reg_num/core_wdata  core request
//   core_gnt/core_valid/core_err/core_rdata   core grant and completion
// Modports:
//   master  requester view (host and core drive requests)
//   slave   arbiter view (drives completions)
interface regfile_access_arbiter_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 91
);
    logic [ADDR_WIDTH-1:0] paddr;
    logic                  pwrite;
    logic                  psel;
    logic                  penable;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    logic                  core_req;
    logic                  core_we;
    logic [ADDR_WIDTH-1:0] core_reg_num;
    logic [DATA_WIDTH-1:0] core_wdata;
    logic                  core_gnt;
    logic                  core_valid;
    logic                  core_err;
    logic [DATA_WIDTH-1:0] core_rdata;

    modport master (
        output paddr, pwrite, psel, penable, pwdata,
        input  prdata, pready, pslverr,
        output core_req, core_we, core_reg_num, core_wdata,
        input  core_gnt, core_valid, core_err, core_rdata
    );

    modport slave (
        input  paddr, pwrite, psel, penable, pwdata,
        output prdata, pready, pslverr,
        input  core_req, core_we, core_reg_num, core_wdata,
        output core_gnt, core_valid, core_err, core_rdata
    );
endinterface

// File: rtl/regfile_access_arbiter.sv
// Shares the single k-means register-file port between the APB host
// and the core: round-robin grant, APB wait states, status protection.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   bus (slave)       APB requester and core register-access port
//   rf_en, rf_we      registered storage strobe and write enable
//   rf_addr, rf_wdata registered storage address and write data
//   rf_rdata          storage read data, valid the cycle after rf_en
module regfile_access_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 91,
    parameter int REG_AMOUNT = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_access_arbiter_if.slave bus,
    output logic                  rf_en,
    output logic                  rf_we,
    output logic [ADDR_WIDTH-1:0] rf_addr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    input  logic [DATA_WIDTH-1:0] rf_rdata
);

    localparam logic [ADDR_WIDTH-1:0] REG_LIMIT = ADDR_WIDTH'(REG_AMOUNT);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP,
        HOLD
    } state_t;

    typedef enum logic {
        GNT_APB  = 1'b0,
        GNT_CORE = 1'b1
    } gnt_t;

    state_t state;
    state_t state_nxt;

    gnt_t gnt;
    gnt_t last_gnt;

    // Attributes of the access currently in flight.
    logic                  err;
    logic                  we;
    logic [DATA_WIDTH-1:0] hold_q;

    // Winner of the IDLE arbitration and its request fields.
    logic                  pick_core;
    gnt_t                  win;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic                  win_we;
    logic [DATA_WIDTH-1:0] win_wdata;
    logic                  win_illegal;

    logic load;
    logic capture;
    logic apb_abort;

    // The core wins only if it asks alone, or on a tie when the APB
    // side had the previous grant. That gives strict alternation.
    always_comb begin
        pick_core = bus.core_req
                  && (!bus.psel || last_gnt == GNT_APB);
        win       = pick_core ? GNT_CORE : GNT_APB;
        win_addr  = pick_core ? bus.core_reg_num : bus.paddr;
        win_we    = pick_core ? bus.core_we : bus.pwrite;
        win_wdata = pick_core ? bus.core_wdata : bus.pwdata;
        // Status register is read-only for the host.
        win_illegal = (win_addr >= REG_LIMIT)
                    || (!pick_core && bus.pwrite
                        && bus.paddr == '0);
    end

    // psel dropping while the host owns the port drops its response.
    assign apb_abort = (gnt == GNT_APB) && !bus.psel;

    always_comb begin
        state_nxt      = state;
        load           = 1'b0;
        capture        = 1'b0;
        bus.pready     = 1'b0;
        bus.pslverr    = 1'b0;
        bus.prdata     = '0;
        bus.core_gnt   = 1'b0;
        bus.core_valid = 1'b0;
        bus.core_err   = 1'b0;
        bus.core_rdata = '0;

        unique case (state)
            IDLE: begin
                if (bus.psel || bus.core_req) begin
                    load      = 1'b1;
                    state_nxt = ISSUE;
                end
            end

            ISSUE: begin
                bus.core_gnt = (gnt == GNT_CORE);
                // The strobe is already out, so an aborted
                // write still lands in storage.
                state_nxt = apb_abort ? IDLE : RESP;
            end

            RESP: begin
                if (gnt == GNT_CORE) begin
                    bus.core_valid = 1'b1;
                    bus.core_err   = err;
                    bus.core_rdata = err ? '0 : rf_rdata;
                    state_nxt      = IDLE;
                end else if (apb_abort) begin
                    state_nxt = IDLE;
                end else if (bus.penable) begin
                    bus.pready  = 1'b1;
                    bus.pslverr = err;
                    bus.prdata  = (err || we) ? '0 : rf_rdata;
                    state_nxt   = IDLE;
                end else begin
                    // Host not in access phase yet: rf_rdata is
                    // only valid now, so keep a copy.
                    capture   = 1'b1;
                    state_nxt = HOLD;
                end
            end

            HOLD: begin
                if (apb_abort) begin
                    state_nxt = IDLE;
                end else if (bus.penable) begin
                    bus.pready  = 1'b1;
                    bus.pslverr = err;
                    bus.prdata  = hold_q;
                    state_nxt   = IDLE;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt      <= GNT_APB;
            last_gnt <= GNT_CORE;
            err      <= 1'b0;
            we       <= 1'b0;
            rf_en    <= 1'b0;
            rf_we    <= 1'b0;
            rf_addr  <= '0;
            rf_wdata <= '0;
        end else begin
            // Strobe lasts exactly the ISSUE cycle.
            rf_en <= 1'b0;
            rf_we <= 1'b0;
            if (load) begin
                gnt      <= win;
                err      <= win_illegal;
                we       <= win_we;
                rf_en    <= !win_illegal;
                rf_we    <= !win_illegal && win_we;
                rf_addr  <= win_addr;
                rf_wdata <= win_wdata;
            end
            if (state == ISSUE) begin
                last_gnt <= gnt;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
        end else if (capture) begin
            hold_q <= (err || we) ? '0 : rf_rdata;
        end
    end

endmodule
